// File: rtl/ssd1306_cmd_controller.sv
// rtl/ssd1306_cmd_controller.sv - SSD1306 command decoder driving a 128x64 bitmap RAM and display config
module ssd1306_cmd_controller (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       ByteValid_i,
    input  logic [7:0] Byte_i,
    input  logic       DC_i,
    input  logic       TransmissionStart_i,
    output logic       WriteEnable_o,
    output logic [9:0] WriteAddress_o,
    output logic [7:0] WriteData_o,
    output logic       DisplayOn_o,
    output logic       Invert_o,
    output logic [7:0] Contrast_o
);

    typedef enum logic [1:0] {S_CMD = 2'd0, S_ARG1 = 2'd1, S_ARG2 = 2'd2} state_t;

    state_t     state, state_next, cur_state;
    logic [7:0] opcode, opcode_next;
    logic [6:0] arg1, arg1_next;
    logic [6:0] column, column_next, col_start, col_start_next, col_end, col_end_next;
    logic [2:0] page, page_next, page_start, page_start_next, page_end, page_end_next;
    logic [1:0] mode, mode_next;
    logic       we_next, display_next, invert_next;
    logic [9:0] waddr_next;
    logic [7:0] wdata_next, contrast_next;

    function automatic logic takes_arg(input logic [7:0] op);
        case (op)
            8'h20, 8'h21, 8'h22, 8'h81, 8'h8D, 8'hA8,
            8'hD3, 8'hD5, 8'hD9, 8'hDA, 8'hDB: takes_arg = 1'b1;
            default:                           takes_arg = 1'b0;
        endcase
    endfunction

    // A chip-select start aborts any pending command before this cycle's byte is decoded
    assign cur_state = TransmissionStart_i ? S_CMD : state;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state          <= S_CMD;
            opcode         <= 8'h00;
            arg1           <= 7'd0;
            column         <= 7'd0;
            page           <= 3'd0;
            col_start      <= 7'd0;
            col_end        <= 7'd127;
            page_start     <= 3'd0;
            page_end       <= 3'd7;
            mode           <= 2'b10;
            WriteEnable_o  <= 1'b0;
            WriteAddress_o <= 10'd0;
            WriteData_o    <= 8'h00;
            DisplayOn_o    <= 1'b0;
            Invert_o       <= 1'b0;
            Contrast_o     <= 8'h7F;
        end else begin
            state          <= state_next;
            opcode         <= opcode_next;
            arg1           <= arg1_next;
            column         <= column_next;
            page           <= page_next;
            col_start      <= col_start_next;
            col_end        <= col_end_next;
            page_start     <= page_start_next;
            page_end       <= page_end_next;
            mode           <= mode_next;
            WriteEnable_o  <= we_next;
            WriteAddress_o <= waddr_next;
            WriteData_o    <= wdata_next;
            DisplayOn_o    <= display_next;
            Invert_o       <= invert_next;
            Contrast_o     <= contrast_next;
        end
    end

    always_comb begin
        state_next  = cur_state;
        opcode_next = opcode;
        if (ByteValid_i) begin
            if (DC_i) begin
                state_next = S_CMD;
            end else begin
                case (cur_state)
                    S_CMD: begin
                        if (takes_arg(Byte_i)) begin
                            state_next  = S_ARG1;
                            opcode_next = Byte_i;
                        end
                    end
                    S_ARG1:  state_next = (opcode == 8'h21 || opcode == 8'h22) ? S_ARG2 : S_CMD;
                    default: state_next = S_CMD;
                endcase
            end
        end
    end

    always_comb begin
        arg1_next       = arg1;
        column_next     = column;
        page_next       = page;
        col_start_next  = col_start;
        col_end_next    = col_end;
        page_start_next = page_start;
        page_end_next   = page_end;
        mode_next       = mode;
        we_next         = 1'b0;
        waddr_next      = WriteAddress_o;
        wdata_next      = WriteData_o;
        display_next    = DisplayOn_o;
        invert_next     = Invert_o;
        contrast_next   = Contrast_o;
        if (ByteValid_i && DC_i) begin
            we_next    = 1'b1;
            waddr_next = {page, column};
            wdata_next = Byte_i;
            case (mode)
                2'b00: begin
                    if (column == col_end) begin
                        column_next = col_start;
                        page_next   = (page == page_end) ? page_start : page + 3'd1;
                    end else begin
                        column_next = column + 7'd1;
                    end
                end
                2'b01: begin
                    if (page == page_end) begin
                        page_next   = page_start;
                        column_next = (column == col_end) ? col_start : column + 7'd1;
                    end else begin
                        page_next = page + 3'd1;
                    end
                end
                default: column_next = column + 7'd1;
            endcase
        end else if (ByteValid_i) begin
            case (cur_state)
                S_CMD: begin
                    if (Byte_i[7:4] == 4'h0)             column_next[3:0] = Byte_i[3:0];
                    else if (Byte_i[7:3] == 5'b00010)    column_next[6:4] = Byte_i[2:0];
                    else if (Byte_i[7:3] == 5'b10110)    page_next        = Byte_i[2:0];
                    else if (Byte_i[7:1] == 7'b1010011)  invert_next      = Byte_i[0];
                    else if (Byte_i[7:1] == 7'b1010111)  display_next     = Byte_i[0];
                end
                S_ARG1: begin
                    case (opcode)
                        8'h20:        if (Byte_i[1:0] != 2'b11) mode_next = Byte_i[1:0];
                        8'h81:        contrast_next = Byte_i;
                        8'h21, 8'h22: arg1_next = Byte_i[6:0];
                        default:      ;
                    endcase
                end
                default: begin
                    // Range commands commit both bounds together on the second argument
                    if (opcode == 8'h21) begin
                        col_start_next = arg1;
                        col_end_next   = Byte_i[6:0];
                        column_next    = arg1;
                    end else if (opcode == 8'h22) begin
                        page_start_next = arg1[2:0];
                        page_end_next   = Byte_i[2:0];
                        page_next       = arg1[2:0];
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ssd1306_cmd_controller.sv
// tb/tb_ssd1306_cmd_controller.sv - directed and randomized checks against a behavioural SSD1306 model
module tb_ssd1306_cmd_controller;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       ByteValid_i = 1'b0;
    logic [7:0] Byte_i = 8'h00;
    logic       DC_i = 1'b0;
    logic       TransmissionStart_i = 1'b0;
    logic       WriteEnable_o;
    logic [9:0] WriteAddress_o;
    logic [7:0] WriteData_o;
    logic       DisplayOn_o;
    logic       Invert_o;
    logic [7:0] Contrast_o;

    ssd1306_cmd_controller dut (
        .Clock               (Clock),
        .Reset               (Reset),
        .ByteValid_i         (ByteValid_i),
        .Byte_i              (Byte_i),
        .DC_i                (DC_i),
        .TransmissionStart_i (TransmissionStart_i),
        .WriteEnable_o       (WriteEnable_o),
        .WriteAddress_o      (WriteAddress_o),
        .WriteData_o         (WriteData_o),
        .DisplayOn_o         (DisplayOn_o),
        .Invert_o            (Invert_o),
        .Contrast_o          (Contrast_o)
    );

    always #5 Clock = ~Clock;

    int tests = 0;
    int fails = 0;

    // Reference model state, kept as plain integers
    int m_col, m_page, m_cs, m_ce, m_ps, m_pe, m_mode;
    int m_contrast, m_disp, m_inv;
    int m_pend, m_op, m_a1;
    int m_we, m_addr, m_data;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_col = 0; m_page = 0; m_cs = 0; m_ce = 127; m_ps = 0; m_pe = 7; m_mode = 2;
        m_contrast = 'h7F; m_disp = 0; m_inv = 0;
        m_pend = 0; m_op = 0; m_a1 = 0;
        m_we = 0; m_addr = 0; m_data = 0;
    endtask

    task automatic model_advance();
        if (m_mode == 0) begin
            if (m_col == m_ce) begin
                m_col  = m_cs;
                m_page = (m_page == m_pe) ? m_ps : (m_page + 1) % 8;
            end else m_col = (m_col + 1) % 128;
        end else if (m_mode == 1) begin
            if (m_page == m_pe) begin
                m_page = m_ps;
                m_col  = (m_col == m_ce) ? m_cs : (m_col + 1) % 128;
            end else m_page = (m_page + 1) % 8;
        end else m_col = (m_col + 1) % 128;
    endtask

    task automatic model_byte(input bit ts, input bit dc, input int b);
        m_we = 0;
        if (ts) m_pend = 0;
        if (dc) begin
            m_we   = 1;
            m_addr = m_page * 128 + m_col;
            m_data = b;
            m_pend = 0;
            model_advance();
        end else if (m_pend == 0) begin
            if (b < 16) m_col = (m_col / 16) * 16 + b;
            else if (b <= 'h17) m_col = (m_col % 16) + (b - 16) * 16;
            else if (b >= 'hB0 && b <= 'hB7) m_page = b - 'hB0;
            else if (b == 'hA6 || b == 'hA7) m_inv = b - 'hA6;
            else if (b == 'hAE || b == 'hAF) m_disp = b - 'hAE;
            if (b inside {'h20, 'h21, 'h22, 'h81, 'h8D, 'hA8, 'hD3, 'hD5, 'hD9, 'hDA, 'hDB}) begin
                m_pend = 1;
                m_op   = b;
            end
        end else if (m_pend == 1) begin
            m_pend = 0;
            if (m_op == 'h20 && (b % 4) != 3) m_mode = b % 4;
            if (m_op == 'h81) m_contrast = b;
            if (m_op == 'h21 || m_op == 'h22) begin
                m_a1   = b;
                m_pend = 2;
            end
        end else begin
            m_pend = 0;
            if (m_op == 'h21) begin
                m_cs = m_a1 % 128; m_ce = b % 128; m_col = m_cs;
            end else begin
                m_ps = m_a1 % 8; m_pe = b % 8; m_page = m_ps;
            end
        end
    endtask

    task automatic check_outputs();
        check("we", WriteEnable_o, m_we);
        if (m_we != 0) begin
            check("addr", WriteAddress_o, m_addr);
            check("data", WriteData_o, m_data);
        end
        check("contrast", Contrast_o, m_contrast);
        check("display_on", DisplayOn_o, m_disp);
        check("invert", Invert_o, m_inv);
    endtask

    task automatic send(input bit dc, input int b, input bit ts);
        @(posedge Clock); #1;
        check("we_one_cycle", WriteEnable_o, 0);
        ByteValid_i = 1'b1;
        Byte_i = b[7:0];
        DC_i = dc;
        TransmissionStart_i = ts;
        model_byte(ts, dc, b);
        @(posedge Clock); #1;
        ByteValid_i = 1'b0;
        TransmissionStart_i = 1'b0;
        check_outputs();
    endtask

    task automatic cmd(input int b);
        send(1'b0, b, 1'b0);
    endtask

    task automatic dat_at(input int b, input int addr);
        send(1'b1, b, 1'b0);
        check("addr_directed", WriteAddress_o, addr);
    endtask

    task automatic tstart();
        @(posedge Clock); #1;
        TransmissionStart_i = 1'b1;
        m_pend = 0;
        @(posedge Clock); #1;
        TransmissionStart_i = 1'b0;
        check("we_after_tstart", WriteEnable_o, 0);
    endtask

    task automatic do_reset();
        @(posedge Clock); #3;
        Reset = 1'b1;
        #1;
        model_reset();
        check("rst_we", WriteEnable_o, 0);
        check("rst_addr", WriteAddress_o, 0);
        check("rst_data", WriteData_o, 0);
        check("rst_display_on", DisplayOn_o, 0);
        check("rst_invert", Invert_o, 0);
        check("rst_contrast", Contrast_o, 'h7F);
        @(posedge Clock); #1;
        Reset = 1'b0;
    endtask

    int picks[16] = '{'h20, 'h21, 'h22, 'h81, 'h8D, 'hA8, 'hD3, 'hDB,
                      'hB5, 'h07, 'h13, 'hA6, 'hA7, 'hAE, 'hAF, 'h01};

    initial begin
        do_reset();

        // Default page mode: consecutive columns
        dat_at('hAA, 0);
        check("data_aa", WriteData_o, 'hAA);
        dat_at('h55, 1);
        check("data_55", WriteData_o, 'h55);

        // Horizontal mode inside a 2x2 window at the bottom-right corner
        cmd('h20); cmd('h00); cmd('h21); cmd('h7E); cmd('h7F); cmd('h22); cmd('h06); cmd('h07);
        dat_at('h01, 894); dat_at('h02, 895); dat_at('h03, 1022); dat_at('h04, 1023); dat_at('h05, 894);

        // Vertical mode inside a 2x2 window at the origin
        cmd('h20); cmd('h01); cmd('h21); cmd('h00); cmd('h01); cmd('h22); cmd('h00); cmd('h01);
        dat_at('h11, 0); dat_at('h12, 128); dat_at('h13, 1); dat_at('h14, 129); dat_at('h15, 0);

        // Page mode column wrap 127 -> 0 on the same page
        cmd('h20); cmd('h02); cmd('hB3); cmd('h0F); cmd('h17);
        dat_at('h21, 511); dat_at('h22, 384);

        // Data aborts a pending contrast command
        cmd('h81);
        dat_at('h12, 385);
        check("contrast_kept", Contrast_o, 'h7F);
        cmd('h81); cmd('h40);
        check("contrast_set", Contrast_o, 'h40);

        cmd('hAF); cmd('hA7);
        check("display_on_set", DisplayOn_o, 1);
        check("invert_set", Invert_o, 1);

        // Transmission start abandons a half-received column range
        cmd('h21); cmd('h00); cmd('h7F); cmd('h22); cmd('h00); cmd('h07);
        cmd('hB0); cmd('h00); cmd('h10);
        cmd('h21); cmd('h10);
        tstart();
        cmd('h20); cmd('h01);
        dat_at('h31, 0); dat_at('h32, 128);
        cmd('h20); cmd('h00); cmd('hB0); cmd('h0F); cmd('h17);
        dat_at('h33, 127); dat_at('h34, 128);

        // Reset in the middle of an argument sequence
        cmd('h81);
        do_reset();
        cmd('h40);
        check("contrast_after_rst", Contrast_o, 'h7F);
        dat_at('h77, 0);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            int r, b;
            bit dc, ts;
            r  = $urandom_range(0, 99);
            dc = ($urandom_range(0, 2) == 0);
            ts = ($urandom_range(0, 15) == 0);
            b  = ($urandom_range(0, 1) == 0) ? picks[$urandom_range(0, 15)] : $urandom_range(0, 255);
            if (r == 0) do_reset();
            else if (r < 4) tstart();
            else send(dc, b, ts);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
